// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state codes and latency bounds.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'h0,
    ST_WAIT = 2'h1,
    ST_ACK  = 2'h2
  } state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;
  localparam int DATA_W      = 32;

endpackage

// File: rtl/mem_responder_ram.sv
// Word RAM with one synchronous read port and one synchronous write port; a read
// that collides with a write to the same word returns the old contents.
module mem_responder_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the cache fill req/ack interface: fixed-latency acks,
// one pending request slot and a sticky overflow flag.
//
// state   | meaning
// IDLE    | no request in flight
// WAIT    | counting down latency for the current request
// ACK     | ack strobe cycle; may promote the pending or a new request
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        o_ack,
  output logic [31:0] o_data,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_ovf,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        cur_addr;
  logic [31:0]        pend_addr;
  logic               pend_v;
  logic               ack;
  logic               err;
  logic               ovf;

  logic               launch;
  logic               finish_wait;
  logic               rd_en;
  logic [31:0]        launch_addr;
  logic [31:0]        rd_addr;
  logic [31:0]        rdata;

  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return !diff[32] && ((diff[31:0] >> 2) < 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  // A request arriving in the ACK cycle with an empty slot starts directly, so
  // it is acked LATENCY cycles after it was sampled.
  always_comb begin
    launch      = 1'b0;
    launch_addr = i_addr;
    finish_wait = 1'b0;
    case (state)
      ST_IDLE: launch = i_req;
      ST_WAIT: finish_wait = (cnt == CNT_W'(1));
      ST_ACK: begin
        launch = pend_v || i_req;
        if (pend_v) launch_addr = pend_addr;
      end
      default: ;
    endcase
    rd_en   = finish_wait || (launch && (LATENCY == 1));
    rd_addr = finish_wait ? cur_addr : launch_addr;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur_addr  <= '0;
      pend_addr <= '0;
      pend_v    <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ack <= rd_en;
      err <= rd_en && !in_range(rd_addr);

      if (launch) begin
        cur_addr <= launch_addr;
        cnt      <= CNT_LOAD;
        state    <= (LATENCY == 1) ? ST_ACK : ST_WAIT;
      end else if (finish_wait) begin
        state <= ST_ACK;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end else if (state != ST_IDLE) begin
        state <= ST_IDLE;
      end

      // The pending slot is freed by promotion in ACK and may be refilled in the same cycle.
      if (state == ST_ACK) begin
        if (pend_v) begin
          pend_v <= i_req;
          if (i_req) pend_addr <= i_addr;
        end
      end else if (state == ST_WAIT && i_req) begin
        if (pend_v) begin
          ovf <= 1'b1;
        end else begin
          pend_v    <= 1'b1;
          pend_addr <= i_addr;
        end
      end
    end
  end

  mem_responder_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (i_wr_en && in_range(i_wr_addr)),
    .waddr (word_idx(i_wr_addr)),
    .wdata (i_wr_data),
    .re    (rd_en),
    .raddr (word_idx(rd_addr)),
    .rdata (rdata)
  );

  assign o_ack  = ack;
  assign o_err  = err;
  assign o_data = (ack && !err) ? rdata : '0;
  assign o_busy = (state != ST_IDLE);
  assign o_ovf  = ovf;

endmodule
